// File: rtl/usb_config_sequencer.sv
// usb_config_sequencer: turns the bridge's 32-bit word stream into addressed
// configuration frame writes. The first word of a transfer is a header
// {8'hFA, start_row, row_count}; the following words are emitted as frames
// through a 1-entry holding buffer with a valid/ready handshake.
// Optional feature: define USB_CONFIG_SEQ_CHECKSUM_EN to expect a trailing
// XOR checksum word after the last frame.
module usb_config_sequencer #(
    parameter int unsigned NUM_ROWS       = 16,
    parameter int unsigned FRAMES_PER_ROW = 20,
    parameter int unsigned ROW_W          = 8,
    parameter int unsigned FRAME_W        = 5
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     word_strobe_i,
    input  logic [31:0]              word_data_i,
    input  logic                     abort_i,
    input  logic                     clear_i,
    output logic                     frame_valid_o,
    input  logic                     frame_ready_i,
    output logic [31:0]              frame_data_o,
    output logic [ROW_W+FRAME_W-1:0] frame_addr_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o
);

    // Wide enough for any 16-bit row_count times FRAMES_PER_ROW.
    localparam int unsigned RemW = 24;

`ifdef USB_CONFIG_SEQ_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StLoad, StCheck, StDone, StError} state_e;
`else
    typedef enum logic [2:0] {StIdle, StLoad, StDone, StError} state_e;
`endif

    state_e             state_q, state_d;
    logic [31:0]        buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [FRAME_W-1:0] idx_q, idx_d;
    logic [RemW-1:0]    rem_q, rem_d;
`ifdef USB_CONFIG_SEQ_CHECKSUM_EN
    logic [31:0]        xor_q, xor_d;
`endif

    logic [7:0]  hdr_start;
    logic [15:0] hdr_count;
    logic        hdr_ok;
    logic        xfer;
    logic        accept;

    assign hdr_start = word_data_i[23:16];
    assign hdr_count = word_data_i[15:0];
    // 17-bit sum so start_row + row_count cannot wrap.
    assign hdr_ok = (word_data_i[31:24] == 8'hFA) && (hdr_count != 16'd0) &&
                    (({9'd0, hdr_start} + {1'b0, hdr_count}) <= 17'(NUM_ROWS));

    assign xfer = (state_q == StLoad) && buf_full_q && frame_ready_i;
    // Once the buffer holds the final data word, further strobes are not data.
    assign accept = word_strobe_i && !(buf_full_q && (rem_q == RemW'(1)));

    // Next-state logic: abort/clear first, then header, data and checksum handling.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        row_d      = row_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
`ifdef USB_CONFIG_SEQ_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        if (clear_i || (abort_i && (state_q != StError))) begin
            state_d    = StIdle;
            buf_full_d = 1'b0;
            row_d      = '0;
            idx_d      = '0;
            rem_d      = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (word_strobe_i) begin
                        if (hdr_ok) begin
                            state_d = StLoad;
                            row_d   = ROW_W'(hdr_start);
                            idx_d   = '0;
                            rem_d   = RemW'(hdr_count) * RemW'(FRAMES_PER_ROW);
`ifdef USB_CONFIG_SEQ_CHECKSUM_EN
                            xor_d   = '0;
`endif
                        end else begin
                            state_d = StError;
                        end
                    end
                end
                StLoad: begin
                    if (xfer) begin
                        buf_full_d = 1'b0;
                        rem_d      = rem_q - RemW'(1);
`ifdef USB_CONFIG_SEQ_CHECKSUM_EN
                        xor_d      = xor_q ^ buf_q;
`endif
                        if (idx_q == FRAME_W'(FRAMES_PER_ROW - 1)) begin
                            idx_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            idx_d = idx_q + FRAME_W'(1);
                        end
                        if (rem_q == RemW'(1)) begin
`ifdef USB_CONFIG_SEQ_CHECKSUM_EN
                            state_d = StCheck;
`else
                            state_d = StDone;
`endif
                        end
                    end
                    if (accept) begin
                        if (buf_full_q && !xfer) begin
                            // Overflow: drop the word and flush the buffer.
                            state_d    = StError;
                            buf_full_d = 1'b0;
                        end else begin
                            buf_d      = word_data_i;
                            buf_full_d = 1'b1;
                        end
                    end
                end
`ifdef USB_CONFIG_SEQ_CHECKSUM_EN
                StCheck: begin
                    if (word_strobe_i) begin
                        state_d = (word_data_i == xor_q) ? StDone : StError;
                    end
                end
`endif
                StDone: begin
                    state_d = StIdle;
                    row_d   = '0;
                    idx_d   = '0;
                    rem_d   = '0;
                end
                StError: begin
                    state_d = StError;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            row_q      <= '0;
            idx_q      <= '0;
            rem_q      <= '0;
`ifdef USB_CONFIG_SEQ_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            row_q      <= row_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
`ifdef USB_CONFIG_SEQ_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    assign frame_valid_o = buf_full_q;
    assign frame_data_o  = buf_q;
    assign frame_addr_o  = {row_q, idx_q};
    assign busy_o        = (state_q != StIdle) && (state_q != StError);
    assign done_o        = (state_q == StDone);
    assign error_o       = (state_q == StError);

endmodule

// File: tb/tb_usb_config_sequencer.sv
// Bench for usb_config_sequencer: directed stimulus, a frame-order model
// (expected data/address queue) checked on every transfer, plus literal checks.
module tb_usb_config_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        word_strobe_i = 1'b0;
    logic [31:0] word_data_i = '0;
    logic        abort_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        frame_valid_o;
    logic        frame_ready_i = 1'b0;
    logic [31:0] frame_data_o;
    logic [12:0] frame_addr_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    usb_config_sequencer dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .word_strobe_i(word_strobe_i),
        .word_data_i  (word_data_i),
        .abort_i      (abort_i),
        .clear_i      (clear_i),
        .frame_valid_o(frame_valid_o),
        .frame_ready_i(frame_ready_i),
        .frame_data_o (frame_data_o),
        .frame_addr_o (frame_addr_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int n_xfer = 0;

    // Model: frames still expected, in order, and the current transfer context.
    logic [31:0] exp_data[$];
    logic [12:0] exp_addr[$];
    int          m_start;
    int          m_i;
    logic [31:0] m_xor;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] addr_of(input int s, input int i);
        return {8'(s + i / 20), 5'(i % 20)};
    endfunction

    // Every accepted frame must be the next one the model expects.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (done_o) done_cnt++;
            if (frame_valid_o && frame_ready_i) begin
                n_xfer++;
                if (exp_data.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL xfer_unexpected: got %h@%h want none", frame_data_o,
                             frame_addr_o);
                end else begin
                    check("xfer_data", frame_data_o, exp_data.pop_front());
                    check("xfer_addr", 32'(frame_addr_o), 32'(exp_addr.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic strobe(input logic [31:0] w);
        word_strobe_i = 1'b1;
        word_data_i   = w;
        tick();
        word_strobe_i = 1'b0;
    endtask

    task automatic send_header(input logic [31:0] w);
        m_start = int'(w[23:16]);
        m_i     = 0;
        m_xor   = '0;
        strobe(w);
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_data.push_back(w);
        exp_addr.push_back(addr_of(m_start, m_i));
        m_i++;
        m_xor ^= w;
        strobe(w);
    endtask

    task automatic flush_model();
        exp_data.delete();
        exp_addr.delete();
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic pulse_abort();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
    endtask

    // Called with the last data word sitting in the buffer and ready high.
    task automatic finish_done(input string name);
        int d0;
        d0 = done_cnt;
        tick();
`ifdef USB_CONFIG_SEQ_CHECKSUM_EN
        check({name, "_check_wait"}, 32'(done_o), 32'd0);
        strobe(m_xor);
`endif
        check({name, "_done"}, 32'(done_o), 32'd1);
        check({name, "_valid_at_done"}, 32'(frame_valid_o), 32'd0);
        tick();
        check({name, "_done_low"}, 32'(done_o), 32'd0);
        check({name, "_busy_low"}, 32'(busy_o), 32'd0);
        check({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_all_sent"}, 32'(exp_data.size()), 32'd0);
    endtask

    logic [31:0] bad_hdr[3];
    int x0;
    int d0;

    initial begin
        bad_hdr[0] = 32'hFB000001;
        bad_hdr[1] = 32'hFA0F0002;
        bad_hdr[2] = 32'hFA000000;

        // Reset
        tick();
        tick();
        check("rst_valid", 32'(frame_valid_o), 32'd0);
        check("rst_data", frame_data_o, 32'd0);
        check("rst_addr", 32'(frame_addr_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);
        reset_i = 1'b0;
        tick();

        // Happy path: rows 1 and 2, 40 frames
        frame_ready_i = 1'b1;
        x0 = n_xfer;
        send_header(32'hFA010002);
        check("happy_busy", 32'(busy_o), 32'd1);
        check("happy_hdr_not_frame", 32'(frame_valid_o), 32'd0);
        for (int i = 0; i < 40; i++) send_word(32'h1000_0000 + 32'(i));
        finish_done("happy");
        check("happy_count", 32'(n_xfer - x0), 32'd40);

        // Backpressure
        frame_ready_i = 1'b0;
        send_header(32'hFA010002);
        send_word(32'h2000_0000);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(frame_valid_o), 32'd1);
            check("bp_data", frame_data_o, 32'h2000_0000);
            check("bp_addr", 32'(frame_addr_o), 32'h020);
            tick();
        end
        x0 = n_xfer;
        frame_ready_i = 1'b1;
        tick();
        check("bp_xfer", 32'(n_xfer - x0), 32'd1);
        check("bp_no_error", 32'(error_o), 32'd0);
        for (int i = 1; i < 40; i++) send_word(32'h2000_0000 + 32'(i));
        finish_done("bp");

        // Overflow
        frame_ready_i = 1'b0;
        send_header(32'hFA000001);
        send_word(32'h3000_0000);
        strobe(32'h3000_0001);
        check("ovf_error", 32'(error_o), 32'd1);
        check("ovf_valid", 32'(frame_valid_o), 32'd0);
        check("ovf_busy", 32'(busy_o), 32'd0);
        strobe(32'h3000_0002);
        check("ovf_ignore_error", 32'(error_o), 32'd1);
        check("ovf_ignore_valid", 32'(frame_valid_o), 32'd0);
        pulse_abort();
        check("ovf_abort_keeps_error", 32'(error_o), 32'd1);
        pulse_clear();
        check("ovf_clear_error", 32'(error_o), 32'd0);
        check("ovf_clear_busy", 32'(busy_o), 32'd0);
        flush_model();

        // Bad headers and the exact-fit boundary
        for (int i = 0; i < 3; i++) begin
            strobe(bad_hdr[i]);
            check("badhdr_error", 32'(error_o), 32'd1);
            check("badhdr_busy", 32'(busy_o), 32'd0);
            pulse_clear();
            check("badhdr_clear", 32'(error_o), 32'd0);
        end
        strobe(32'hFA0E0002);
        check("fit_busy", 32'(busy_o), 32'd1);
        check("fit_error", 32'(error_o), 32'd0);
        pulse_abort();
        check("fit_abort", 32'(busy_o), 32'd0);

        // Abort mid-transfer after 5 frames
        frame_ready_i = 1'b1;
        d0 = done_cnt;
        x0 = n_xfer;
        send_header(32'hFA010002);
        for (int i = 0; i < 5; i++) send_word(32'h4000_0000 + 32'(i));
        tick();
        check("abort_5_frames", 32'(n_xfer - x0), 32'd5);
        pulse_abort();
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_valid", 32'(frame_valid_o), 32'd0);
        check("abort_error", 32'(error_o), 32'd0);
        tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        flush_model();
        // Abort wins over a simultaneous header strobe
        abort_i = 1'b1;
        strobe(32'hFA000001);
        abort_i = 1'b0;
        check("abort_prio_busy", 32'(busy_o), 32'd0);
        frame_ready_i = 1'b0;
        send_header(32'hFA000001);
        send_word(32'h5000_0000);
        check("restart_valid", 32'(frame_valid_o), 32'd1);
        check("restart_addr", 32'(frame_addr_o), 32'h000);
        frame_ready_i = 1'b1;
        for (int i = 1; i < 20; i++) send_word(32'h5000_0000 + 32'(i * 7));
        finish_done("restart");

`ifdef USB_CONFIG_SEQ_CHECKSUM_EN
        // Wrong checksum
        d0 = done_cnt;
        send_header(32'hFA000001);
        for (int i = 0; i < 20; i++) send_word(32'h6000_0000 + 32'(i * 3));
        tick();
        strobe(m_xor ^ 32'd1);
        check("cks_bad_error", 32'(error_o), 32'd1);
        check("cks_bad_done", 32'(done_o), 32'd0);
        tick();
        check("cks_bad_no_done", 32'(done_cnt - d0), 32'd0);
        pulse_clear();
        check("cks_bad_clear", 32'(error_o), 32'd0);
        flush_model();
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
